instr_encoder_loader: RTL

//  Inverse of the datapath's immediate/operand decode: accepts decoded RV32I fields over a

---
 rtl/instr_encoder_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I field bundles into 32-bit
// instruction words and writes them to consecutive instruction-memory
// addresses. Handshake in cycle N produces the memory write in cycle N+1.
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [6:0]        i_in_opcode,
    input  logic [4:0]        i_in_rd,
    input  logic [2:0]        i_in_funct3,
    input  logic [4:0]        i_in_rs1,
    input  logic [4:0]        i_in_rs2,
    input  logic [6:0]        i_in_funct7,
    input  logic [31:0]       i_in_imm,
    input  logic              i_in_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LD   = 7'b0000011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_I_SYS  = 7'b1110011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_U_LUI  = 7'b0110111;
    localparam logic [6:0] OP_U_AUI  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         r_word;
    logic                r_last;

    logic [31:0]         w_word;
    logic                w_legal;

    // Format-dependent packing of the incoming bundle; flags unknown opcodes
    // and odd branch/jump offsets as illegal.
    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        unique case (i_in_opcode)
            OP_R:
                w_word = {i_in_funct7, i_in_rs2, i_in_rs1, i_in_funct3, i_in_rd, i_in_opcode};
            OP_I_ALU, OP_I_LD, OP_I_JALR, OP_I_SYS:
                w_word = {i_in_imm[11:0], i_in_rs1, i_in_funct3, i_in_rd, i_in_opcode};
            OP_S:
                w_word = {i_in_imm[11:5], i_in_rs2, i_in_rs1, i_in_funct3,
                          i_in_imm[4:0], i_in_opcode};
            OP_B: begin
                w_word  = {i_in_imm[12], i_in_imm[10:5], i_in_rs2, i_in_rs1, i_in_funct3,
                           i_in_imm[4:1], i_in_imm[11], i_in_opcode};
                w_legal = ~i_in_imm[0];
            end
            OP_U_LUI, OP_U_AUI:
                w_word = {i_in_imm[31:12], i_in_rd, i_in_opcode};
            OP_J: begin
                w_word  = {i_in_imm[20], i_in_imm[10:1], i_in_imm[11], i_in_imm[19:12],
                           i_in_rd, i_in_opcode};
                w_legal = ~i_in_imm[0];
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Control FSM: start overrides everything, including a pending write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_word  <= 32'h0;
            r_last  <= 1'b0;
        end else if (i_start) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (i_in_valid) begin
                        if (w_legal) begin
                            r_word  <= w_word;
                            r_last  <= i_in_last;
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                end
                S_WRITE: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= r_count + 1'b1;
                    // Top address is still written before flagging overflow.
                    if (r_last)
                        r_state <= S_DONE;
                    else if (r_ptr == {ADDR_W{1'b1}})
                        r_state <= S_ERR;
                    else
                        r_state <= S_LOAD;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_LOAD);
    assign o_mem_we    = (r_state == S_WRITE) && !i_start;
    assign o_mem_addr  = r_ptr;
    assign o_mem_wdata = r_word;
    assign o_busy      = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = (r_state == S_ERR);
    assign o_count     = r_count;

endmodule
